// File: rtl/mpt_response_stage_if.sv
// Shared MPT fault types plus the request/response channel bundle of the response stage.
// The slave modport is the stage; the master modport is the upstream register plus the requester.
package mpt_response_stage_pkg;
  typedef enum logic [2:0] {
    NO_ERROR        = 3'd0,
    NOT_VALID_ADDR  = 3'd1,
    RESERVED_MPTE   = 3'd2,
    INVALID_BIT_SET = 3'd3,
    MPTE_ACCESS_ERR = 3'd4
  } page_format_fault_e;

  localparam int ACCESS_ERR_W = 2;
endpackage

interface mpt_response_stage_if
  import mpt_response_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SPA_WIDTH  = 64
);
  logic                    stage_slave_valid;
  logic                    stage_slave_ready;
  logic [DATA_WIDTH-1:0]   stage_slave_data;
  logic                    resp_valid_o;
  logic                    resp_ready_i;
  logic                    resp_allow_o;
  page_format_fault_e      resp_format_error_o;
  logic [ACCESS_ERR_W-1:0] resp_access_error_o;
  logic [SPA_WIDTH-1:0]    resp_spa_o;
  logic                    resp_plb_hit_o;

  modport slave (
    input  stage_slave_valid, stage_slave_data, resp_ready_i,
    output stage_slave_ready, resp_valid_o, resp_allow_o, resp_format_error_o,
           resp_access_error_o, resp_spa_o, resp_plb_hit_o
  );

  modport master (
    output stage_slave_valid, stage_slave_data, resp_ready_i,
    input  stage_slave_ready, resp_valid_o, resp_allow_o, resp_format_error_o,
           resp_access_error_o, resp_spa_o, resp_plb_hit_o
  );
endinterface

// File: rtl/mpt_response_stage.sv
// MPT pipeline tail: drops bubbles, buffers allow/deny responses in a FIFO, keeps saturating stats.
// Latency 1 cycle (no bypass); input ready falls when full unless the requester pops or a flush is in progress.
module mpt_response_stage
  import mpt_response_stage_pkg::*;
#(
  parameter int PIPELINE_SLAVE_DATA_WIDTH = 32,
  parameter int RESP_FIFO_DEPTH           = 2,
  parameter int SPA_WIDTH                 = 64,
  parameter int CNT_WIDTH                 = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  mpt_response_stage_if.slave  bus,
  output logic [CNT_WIDTH-1:0] resp_count_o,
  output logic [CNT_WIDTH-1:0] deny_count_o
);
  localparam int AW = $clog2(RESP_FIFO_DEPTH);

  typedef struct packed {
    logic                                  valid;
    logic                                  walking;
    logic                                  plb_hit;
    page_format_fault_e                    format_error;
    logic [ACCESS_ERR_W-1:0]               access_error;
    logic [7:0]                            mpte;
    logic [PIPELINE_SLAVE_DATA_WIDTH-17:0] spa;
  } mptw_transaction_t;

  typedef struct packed {
    logic                    allow;
    page_format_fault_e      format_error;
    logic [ACCESS_ERR_W-1:0] access_error;
    logic [SPA_WIDTH-1:0]    spa;
    logic                    plb_hit;
  } entry_t;

  mptw_transaction_t txn;
  entry_t            wr_entry;
  entry_t            head;
  entry_t            mem [RESP_FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       occ;
  logic              full;
  logic              empty;
  logic              push_hs;
  logic              push;
  logic              pop;
  logic              txn_unused;

  assign txn        = mptw_transaction_t'(bus.stage_slave_data);
  assign txn_unused = ^{txn.walking, txn.mpte};

  always_comb begin
    wr_entry.allow        = (txn.format_error == NO_ERROR) && (txn.access_error == '0);
    wr_entry.format_error = txn.format_error;
    wr_entry.access_error = txn.access_error;
    wr_entry.spa          = SPA_WIDTH'(txn.spa);
    wr_entry.plb_hit      = txn.plb_hit;
  end

  assign full                  = (occ == (AW+1)'(RESP_FIFO_DEPTH));
  assign empty                 = (occ == '0);
  assign bus.stage_slave_ready = ~rst_i & (~full | bus.resp_ready_i | flush_i);
  assign push_hs               = bus.stage_slave_valid & bus.stage_slave_ready;
  // Bubbles complete the handshake but never reach the buffer.
  assign push                  = push_hs & txn.valid & ~flush_i;
  assign pop                   = bus.resp_valid_o & bus.resp_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // A pop completing in a flush cycle still counts; flush never clears stats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_count_o <= '0;
      deny_count_o <= '0;
    end else if (pop) begin
      if (resp_count_o != '1) resp_count_o <= resp_count_o + CNT_WIDTH'(1);
      if (!head.allow && deny_count_o != '1) deny_count_o <= deny_count_o + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    head                    = mem[rd_ptr];
    bus.resp_valid_o        = ~empty;
    bus.resp_allow_o        = 1'b0;
    bus.resp_format_error_o = NO_ERROR;
    bus.resp_access_error_o = '0;
    bus.resp_spa_o          = '0;
    bus.resp_plb_hit_o      = 1'b0;
    if (!empty) begin
      bus.resp_allow_o        = head.allow;
      bus.resp_format_error_o = head.format_error;
      bus.resp_access_error_o = head.access_error;
      bus.resp_spa_o          = head.spa;
      bus.resp_plb_hit_o      = head.plb_hit;
    end
  end
endmodule

// File: tb/tb_mpt_response_stage.sv
// Directed bench: vector table for single responses, plus sequences for backpressure, streaming, flush, saturation, reset.
module tb_mpt_response_stage;
  import mpt_response_stage_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, rst4, flush4;
  logic [31:0] rc, dc;
  logic [3:0]  rc4, dc4;
  int n_vec = 0;
  int n_err = 0;
  int exp_rc = 0;
  int exp_dc = 0;

  always #5 clk = ~clk;

  mpt_response_stage_if #(.DATA_WIDTH(32), .SPA_WIDTH(64)) bus ();
  mpt_response_stage_if #(.DATA_WIDTH(32), .SPA_WIDTH(64)) b4 ();

  mpt_response_stage #(.PIPELINE_SLAVE_DATA_WIDTH(32), .RESP_FIFO_DEPTH(2), .SPA_WIDTH(64), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus), .resp_count_o(rc), .deny_count_o(dc));

  mpt_response_stage #(.PIPELINE_SLAVE_DATA_WIDTH(32), .RESP_FIFO_DEPTH(2), .SPA_WIDTH(64), .CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .flush_i(flush4), .bus(b4), .resp_count_o(rc4), .deny_count_o(dc4));

  typedef struct {
    logic               v;
    logic               plb;
    page_format_fault_e fe;
    logic [1:0]         ae;
    logic [15:0]        spa;
    logic               exp_allow;
  } vec_t;

  vec_t vt [6];

  function automatic logic [31:0] mk(logic v, logic plb, page_format_fault_e fe, logic [1:0] ae, logic [15:0] spa);
    return {v, 1'b0, plb, fe, ae, 8'h5A, spa};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] d);
    bus.stage_slave_valid = v;
    bus.stage_slave_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, NO_ERROR,        2'd0, 16'h1000, 1'b1};
    vt[1] = '{1'b1, 1'b1, NOT_VALID_ADDR,  2'd0, 16'h2000, 1'b0};
    vt[2] = '{1'b0, 1'b0, NO_ERROR,        2'd0, 16'h3000, 1'b1};
    vt[3] = '{1'b1, 1'b1, NO_ERROR,        2'd2, 16'hBEEF, 1'b0};
    vt[4] = '{1'b1, 1'b0, INVALID_BIT_SET, 2'd1, 16'h0001, 1'b0};
    vt[5] = '{1'b1, 1'b1, NO_ERROR,        2'd0, 16'hFFFF, 1'b1};

    rst = 1'b1; rst4 = 1'b1; flush = 1'b0; flush4 = 1'b0;
    drive(1'b0, '0);
    bus.resp_ready_i = 1'b1;
    b4.stage_slave_valid = 1'b0; b4.stage_slave_data = '0; b4.resp_ready_i = 1'b1;
    cyc();
    check("reset_ready", bus.stage_slave_ready, 0);
    check("reset_valid", bus.resp_valid_o, 0);
    check("reset_rc", rc, 0);
    check("reset_dc", dc, 0);
    cyc();
    rst = 1'b0; rst4 = 1'b0;
    cyc();

    // single transactions from the table
    foreach (vt[i]) begin
      drive(1'b1, mk(vt[i].v, vt[i].plb, vt[i].fe, vt[i].ae, vt[i].spa));
      #1;
      check($sformatf("v%0d_in_ready", i), bus.stage_slave_ready, 1);
      cyc();
      drive(1'b0, '0);
      #1;
      check($sformatf("v%0d_valid", i), bus.resp_valid_o, vt[i].v);
      if (vt[i].v) begin
        check($sformatf("v%0d_allow", i), bus.resp_allow_o, vt[i].exp_allow);
        check($sformatf("v%0d_fe", i), bus.resp_format_error_o, vt[i].fe);
        check($sformatf("v%0d_ae", i), bus.resp_access_error_o, vt[i].ae);
        check($sformatf("v%0d_spa", i), bus.resp_spa_o, {48'h0, vt[i].spa});
        check($sformatf("v%0d_plb", i), bus.resp_plb_hit_o, vt[i].plb);
        exp_rc++;
        if (!vt[i].exp_allow) exp_dc++;
      end
      cyc();
      check($sformatf("v%0d_one_cycle", i), bus.resp_valid_o, 0);
      check($sformatf("v%0d_rc", i), rc, exp_rc);
      check($sformatf("v%0d_dc", i), dc, exp_dc);
    end

    // backpressure: two accepts fill the buffer, third waits
    bus.resp_ready_i = 1'b0;
    drive(1'b1, mk(1'b1, 1'b0, NO_ERROR, 2'd0, 16'h00A0));
    #1; check("bp_rdy_a", bus.stage_slave_ready, 1);
    cyc();
    drive(1'b1, mk(1'b1, 1'b0, NO_ERROR, 2'd0, 16'h00B0));
    #1; check("bp_rdy_b", bus.stage_slave_ready, 1);
    check("bp_head_a0", bus.resp_spa_o, 64'hA0);
    cyc();
    drive(1'b1, mk(1'b1, 1'b0, NO_ERROR, 2'd0, 16'h00C0));
    #1; check("bp_full_rdy", bus.stage_slave_ready, 0);
    check("bp_head_a1", bus.resp_spa_o, 64'hA0);
    cyc();
    check("bp_head_stable", bus.resp_spa_o, 64'hA0);
    check("bp_full_rdy2", bus.stage_slave_ready, 0);
    bus.resp_ready_i = 1'b1;
    #1; check("bp_pop_rdy", bus.stage_slave_ready, 1);
    cyc();
    drive(1'b0, '0);
    bus.resp_ready_i = 1'b0;
    #1; check("bp_still_full", bus.stage_slave_ready, 0);
    check("bp_head_b", bus.resp_spa_o, 64'hB0);
    exp_rc++;
    bus.resp_ready_i = 1'b1;
    cyc();
    check("bp_head_c", bus.resp_spa_o, 64'hC0);
    check("bp_valid_c", bus.resp_valid_o, 1);
    cyc();
    check("bp_drained", bus.resp_valid_o, 0);
    exp_rc += 2;
    check("bp_rc", rc, exp_rc);

    // back-to-back stream exercising pointer wrap
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drive(1'b1, mk(1'b1, 1'b0, NO_ERROR, 2'd0, 16'(16'h0100 + k)));
      else       drive(1'b0, '0);
      #1;
      if (k > 0) begin
        check($sformatf("st%0d_valid", k), bus.resp_valid_o, 1);
        check($sformatf("st%0d_spa", k), bus.resp_spa_o, 64'(32'h100 + k - 1));
      end else begin
        check("st0_empty", bus.resp_valid_o, 0);
      end
      cyc();
    end
    check("st_end", bus.resp_valid_o, 0);
    exp_rc += 8;
    check("st_rc", rc, exp_rc);

    // flush with a simultaneous input handshake
    bus.resp_ready_i = 1'b0;
    drive(1'b1, mk(1'b1, 1'b0, NO_ERROR, 2'd0, 16'h00D0)); cyc();
    drive(1'b1, mk(1'b1, 1'b0, NO_ERROR, 2'd0, 16'h00E0)); cyc();
    check("fl_full_valid", bus.resp_valid_o, 1);
    check("fl_full_rdy", bus.stage_slave_ready, 0);
    flush = 1'b1;
    drive(1'b1, mk(1'b1, 1'b0, NO_ERROR, 2'd0, 16'h000F));
    #1; check("fl_rdy", bus.stage_slave_ready, 1);
    cyc();
    flush = 1'b0;
    drive(1'b0, '0);
    #1; check("fl_empty", bus.resp_valid_o, 0);
    check("fl_rc", rc, exp_rc);
    check("fl_dc", dc, exp_dc);
    cyc();
    check("fl_dropped", bus.resp_valid_o, 0);
    bus.resp_ready_i = 1'b1;
    drive(1'b1, mk(1'b1, 1'b1, NO_ERROR, 2'd0, 16'h0077)); cyc();
    drive(1'b0, '0);
    #1; check("fl_after_spa", bus.resp_spa_o, 64'h77);
    check("fl_after_valid", bus.resp_valid_o, 1);
    exp_rc++;
    cyc();
    check("fl_after_rc", rc, exp_rc);

    // saturation on the 4-bit counter build
    for (int k = 0; k < 20; k++) begin
      b4.stage_slave_valid = 1'b1;
      b4.stage_slave_data  = mk(1'b1, 1'b0, NOT_VALID_ADDR, 2'd0, 16'(k));
      cyc();
    end
    b4.stage_slave_valid = 1'b0;
    cyc();
    cyc();
    check("sat_rc4", rc4, 15);
    check("sat_dc4", dc4, 15);

    // reset with responses still buffered
    b4.resp_ready_i = 1'b0;
    b4.stage_slave_valid = 1'b1;
    b4.stage_slave_data  = mk(1'b1, 1'b1, NO_ERROR, 2'd0, 16'h0055); cyc();
    b4.stage_slave_data  = mk(1'b1, 1'b1, NO_ERROR, 2'd0, 16'h0066); cyc();
    check("rst4_pre_valid", b4.resp_valid_o, 1);
    rst4 = 1'b1;
    #1; check("rst4_rdy", b4.stage_slave_ready, 0);
    cyc();
    check("rst4_valid", b4.resp_valid_o, 0);
    check("rst4_spa", b4.resp_spa_o, 0);
    check("rst4_rc", rc4, 0);
    check("rst4_dc", dc4, 0);
    b4.stage_slave_valid = 1'b0;
    rst4 = 1'b0;
    cyc();
    check("rst4_after_valid", b4.resp_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
